// File: rtl/field_pkg.sv
// Shared playfield geometry, cell indexing and line-clear FSM encoding.
// Used by the line-clear engine, the background latch and the collision checker.
package field_pkg;

   localparam int FIELD_ROWS = 20;
   localparam int FIELD_COLS = 20;
   localparam int FIELD_BITS = FIELD_ROWS * FIELD_COLS;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } field_state_e;

   // Row 0 is the top row; cell (r,c) lives at bit r*COLS+c.
   function automatic int cell_idx(input int r, input int c);
      return r * FIELD_COLS + c;
   endfunction

endpackage

// File: rtl/field_row_full.sv
// Combinational test: is row ptr of the field completely occupied?
module field_row_full
   import field_pkg::*;
#(
   parameter int ROWS  = FIELD_ROWS,
   parameter int COLS  = FIELD_COLS,
   parameter int PTR_W = $clog2(ROWS)
) (
   input  logic [ROWS*COLS-1:0] field,
   input  logic [PTR_W-1:0]     ptr,
   output logic                 full
);

   always_comb begin
      full = &field[ptr*COLS +: COLS];
   end

endmodule

// File: rtl/field_line_clear.sv
// Scans the settled field bottom-up one row per cycle, removing full rows and
// dropping everything above them; returns the compacted field with a done pulse.
module field_line_clear
   import field_pkg::*;
#(
   parameter int ROWS  = FIELD_ROWS,
   parameter int COLS  = FIELD_COLS,
   parameter int CNT_W = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ROWS*COLS-1:0]  field_in,
   output logic                  busy,
   output logic                  done,
   output logic [ROWS*COLS-1:0]  field_out,
   output logic [CNT_W-1:0]      lines_cleared,
   output field_state_e          dbg_state
);

   localparam int PTR_W = $clog2(ROWS);
   localparam int BITS  = ROWS * COLS;
   localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(ROWS - 1);

   // Handshake: start is sampled only in IDLE; busy covers the scan; done is a
   // single-cycle pulse and field_out/lines_cleared hold until the next done.
   field_state_e     state_q, state_d;
   logic [BITS-1:0]  work_q, work_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [BITS-1:0]  field_out_q, field_out_d;
   logic [CNT_W-1:0] lines_q, lines_d;
   logic             row_full;

   field_row_full #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .PTR_W (PTR_W)
   ) u_row_full (
      .field (work_q),
      .ptr   (ptr_q),
      .full  (row_full)
   );

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      field_out_d = field_out_q;
      lines_d     = lines_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               work_d  = field_in;
               ptr_d   = PTR_TOP;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (row_full) begin
               // Drop rows 0..ptr-1 by one; ptr stays so the new row ptr is re-examined.
               for (int r = 0; r < ROWS; r++) begin
                  if (r == 0) begin
                     work_d[0 +: COLS] = '0;
                  end else if (PTR_W'(r) <= ptr_q) begin
                     work_d[r*COLS +: COLS] = work_q[(r-1)*COLS +: COLS];
                  end
               end
               cnt_d = cnt_q + CNT_W'(1);
            end else if (ptr_q != '0) begin
               ptr_d = ptr_q - PTR_W'(1);
            end else begin
               field_out_d = work_q;
               lines_d     = cnt_q;
               done_d      = 1'b1;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         work_q      <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         field_out_q <= '0;
         lines_q     <= '0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         field_out_q <= field_out_d;
         lines_q     <= lines_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign field_out     = field_out_q;
   assign lines_cleared = lines_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_field_line_clear.sv
// Randomized and directed bench for field_line_clear against a row-list model.
module tb_field_line_clear;
   import field_pkg::*;

   localparam int ROWS  = FIELD_ROWS;
   localparam int COLS  = FIELD_COLS;
   localparam int BITS  = FIELD_BITS;
   localparam int CNT_W = 5;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic [BITS-1:0]  field_in;
   logic             busy;
   logic             done;
   logic [BITS-1:0]  field_out;
   logic [CNT_W-1:0] lines_cleared;
   field_state_e     dbg_state;

   int n_vec;
   int n_err;
   logic [BITS-1:0] last_out;
   int              last_k;

   field_line_clear #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .CNT_W (CNT_W)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .field_in      (field_in),
      .busy          (busy),
      .done          (done),
      .field_out     (field_out),
      .lines_cleared (lines_cleared),
      .dbg_state     (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: keep the non-full rows in bottom-up order, stack them at the bottom.
   task automatic model(input logic [BITS-1:0] f, output logic [BITS-1:0] o, output int k);
      logic [COLS-1:0] keep[$];
      logic [COLS-1:0] row;
      k = 0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         row = f[r*COLS +: COLS];
         if (row == {COLS{1'b1}}) k++;
         else keep.push_back(row);
      end
      o = '0;
      for (int i = 0; i < keep.size(); i++) o[(ROWS-1-i)*COLS +: COLS] = keep[i];
   endtask

   function automatic logic [BITS-1:0] rand_field();
      logic [BITS-1:0] f;
      logic [COLS-1:0] row;
      for (int r = 0; r < ROWS; r++) begin
         row = COLS'({$urandom, $urandom});
         if ($urandom_range(0, 2) == 0) row = {COLS{1'b1}};
         f[r*COLS +: COLS] = row;
      end
      return f;
   endfunction

   // Runs one operation. When b2b is set the caller is already in the done cycle
   // and start is raised right away. inj>0 pulses a spurious start at that edge.
   task automatic do_op(input string name, input logic [BITS-1:0] f, input bit b2b, input int inj);
      logic [BITS-1:0] exp_o;
      int exp_k, lat, busy_cyc;
      model(f, exp_o, exp_k);
      if (!b2b) @(negedge clk);
      field_in = f;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      field_in = rand_field();
      lat      = -1;
      busy_cyc = busy ? 1 : 0;
      for (int n = 1; n <= 100; n++) begin
         if (inj > 0 && n == inj) start = 1'b1;
         @(posedge clk);
         #1;
         if (inj > 0 && n == inj) start = 1'b0;
         if (n == 3) begin
            check({name, "_hold_out"}, field_out, last_out);
            check({name, "_hold_cnt"}, BITS'(lines_cleared), BITS'(last_k));
         end
         if (done) begin
            lat = n;
            break;
         end
         if (busy) busy_cyc++;
      end
      check({name, "_latency"}, BITS'(lat), BITS'(ROWS + exp_k));
      check({name, "_busy_cycles"}, BITS'(busy_cyc), BITS'(ROWS + exp_k));
      check({name, "_busy_at_done"}, BITS'(busy), '0);
      check({name, "_field_out"}, field_out, exp_o);
      check({name, "_lines"}, BITS'(lines_cleared), BITS'(exp_k));
      last_out = exp_o;
      last_k   = exp_k;
   endtask

   task automatic expect_quiet(input string name, input int edges);
      int pulses;
      pulses = 0;
      for (int n = 0; n < edges; n++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      check({name, "_no_extra_done"}, BITS'(pulses), '0);
   endtask

   initial begin
      logic [BITS-1:0] f;
      n_vec    = 0;
      n_err    = 0;
      last_out = '0;
      last_k   = 0;
      start    = 1'b0;
      field_in = '0;
      reset_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", BITS'(busy), '0);
      check("rst_done", BITS'(done), '0);
      check("rst_out", field_out, '0);
      check("rst_lines", BITS'(lines_cleared), '0);
      check("rst_state", BITS'(dbg_state), BITS'(ST_IDLE));
      @(negedge clk);
      reset_n = 1'b1;

      do_op("empty", '0, 1'b0, 0);
      expect_quiet("empty", 3);

      f = '0;
      f[399:380] = '1;
      f[360] = 1'b1;
      do_op("row19", f, 1'b0, 0);
      check("row19_const", field_out, BITS'(1) << 380);

      f = '0;
      f[399:380] = '1;
      f[359:340] = '1;
      f[360] = 1'b1;
      f[339] = 1'b1;
      do_op("rows19_17", f, 1'b0, 0);
      check("rows19_17_const", field_out, (BITS'(1) << 380) | (BITS'(1) << 379));

      do_op("all_ones", '1, 1'b0, 0);

      f = '0;
      f[19:0] = '1;
      do_op("row0", f, 1'b0, 0);

      do_op("ignore_start", '0, 1'b0, 5);
      expect_quiet("ignore_start", ROWS + 2);

      // back-to-back: start raised in the done cycle
      do_op("b2b_a", rand_field(), 1'b0, 0);
      do_op("b2b_b", rand_field(), 1'b1, 0);

      // reset mid-scan
      @(negedge clk);
      field_in = '1;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_busy", BITS'(busy), '0);
      check("midrst_done", BITS'(done), '0);
      check("midrst_out", field_out, '0);
      check("midrst_lines", BITS'(lines_cleared), '0);
      check("midrst_state", BITS'(dbg_state), BITS'(ST_IDLE));
      @(negedge clk);
      reset_n  = 1'b1;
      last_out = '0;
      last_k   = 0;
      expect_quiet("midrst", 5);

      for (int i = 0; i < 30; i++) begin
         do_op($sformatf("rand%0d", i), rand_field(), ($urandom_range(0, 1) == 1), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
